// File: rtl/nanov_uart_tx_if.sv
// CPU-side store bus of the nanov UART transmitter.
// master = CPU (drives the store strobe), slave = the transmitter.
interface nanov_uart_tx_if;
    logic [31:0] data_in;
    logic        store_in;
    logic        busy;
    logic        overflow;

    modport master (
        output data_in,
        output store_in,
        input  busy,
        input  overflow
    );

    modport slave (
        input  data_in,
        input  store_in,
        output busy,
        output overflow
    );
endinterface

// File: rtl/nanov_uart_tx.sv
// 8N1 UART transmitter fed by CPU stores. NANOV_UART_FIFO_EN selects a 4-entry
// FIFO queue; without it the queue is a single holding register.
module nanov_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rstn,
    nanov_uart_tx_if.slave    bus,
    output logic              uart_tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            uart_tx_q, uart_tx_d;
    logic            busy_q, busy_d;
    logic            overflow_q, overflow_d;

    logic            q_full;
    logic            q_empty;
    logic [7:0]      q_head;
    logic            q_nonempty_d;
    logic            bit_end;
    logic            pop;
    logic            push;

    // Only the low byte of the store bus is payload.
    logic            unused_upper;
    assign unused_upper = ^bus.data_in[31:8];

    assign bit_end = (cnt_q == CNT_LAST);
    assign pop     = (state_q == IDLE) && !q_empty;
    assign push    = bus.store_in && (!q_full || pop);

`ifdef NANOV_UART_FIFO_EN
    logic [7:0] mem_q [4];
    logic [7:0] mem_d [4];
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [2:0] count_q, count_d;

    assign q_full  = (count_q == 3'd4);
    assign q_empty = (count_q == 3'd0);
    assign q_head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.data_in[7:0];
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        count_d = count_q + 3'(push) - 3'(pop);
    end

    assign q_nonempty_d = (count_d != 3'd0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end
`else
    logic [7:0] hold_q, hold_d;
    logic       valid_q, valid_d;

    assign q_full  = valid_q;
    assign q_empty = !valid_q;
    assign q_head  = hold_q;

    // A push in the same cycle as the pop refills the register immediately.
    always_comb begin
        hold_d  = hold_q;
        valid_d = valid_q;
        if (pop) begin
            valid_d = 1'b0;
        end
        if (push) begin
            hold_d  = bus.data_in[7:0];
            valid_d = 1'b1;
        end
    end

    assign q_nonempty_d = valid_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && (bit_idx_q == 3'd7)) state_d = STOP;
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Line level is derived from the next state so uart_tx comes straight off a flop.
    always_comb begin
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (pop) shift_d = q_head;
            end
            DATA: begin
                cnt_d = bit_end ? '0 : cnt_q + CW'(1);
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            default: cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        endcase

        case (state_d)
            START:   uart_tx_d = 1'b0;
            DATA:    uart_tx_d = shift_d[0];
            default: uart_tx_d = 1'b1;
        endcase

        busy_d     = (state_d != IDLE) || q_nonempty_d;
        overflow_d = overflow_q || (bus.store_in && q_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            uart_tx_q  <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            uart_tx_q  <= uart_tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign uart_tx      = uart_tx_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_nanov_uart_tx.sv
// Self-checking bench for nanov_uart_tx: frame-level reference model compared
// every cycle, an independent line decoder, and hand-computed literal checks.
module tb_nanov_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
`ifdef NANOV_UART_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic clk;
    logic rstn;
    logic uart_tx;

    nanov_uart_tx_if bus_if ();

    nanov_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus_if.slave),
        .uart_tx (uart_tx)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: queue of pending bytes plus position within the current frame.
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];
    int         m_pos = -1;
    logic [7:0] m_byte = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_tx = 1'b1;
    logic       m_busy = 1'b0;
    bit         model_valid = 1'b0;
    bit         m_pop, m_full, m_accept;

    // Line decoder: bytes recovered from the DUT serial output.
    logic [7:0] rx_bytes[$];
    bit         rx_active = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_shift = 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkBytes(input string name, input logic [7:0] act[$], input logic [7:0] exp[$]);
        checkOutput({name, " count"}, act.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < act.size()) checkOutput($sformatf("%s[%0d]", name, i), act[i], exp[i]);
        end
    endtask

    // Drives inputs just after an edge; they are sampled at the following edge.
    task automatic applyStimulus(input logic [31:0] d, input logic st, input logic rn);
        @(posedge clk);
        #1;
        bus_if.data_in  = d;
        bus_if.store_in = st;
        rstn            = rn;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(32'h0, 1'b0, 1'b1);
    endtask

    task automatic doReset();
        applyStimulus(32'h0, 1'b0, 1'b0);
        applyStimulus(32'h0, 1'b0, 1'b1);
        rx_bytes.delete();
        m_sent.delete();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!rstn) begin
                m_q.delete();
                m_pos       = -1;
                m_ovf       = 1'b0;
                model_valid = 1'b1;
            end else begin
                m_pop    = (m_pos < 0) && (m_q.size() > 0);
                m_full   = (m_q.size() >= DEPTH);
                m_accept = bus_if.store_in && (!m_full || m_pop);
                if (m_pop) begin
                    m_byte = m_q.pop_front();
                    m_sent.push_back(m_byte);
                    m_pos = 0;
                end else if (m_pos >= 0) begin
                    m_pos++;
                    if (m_pos == FRAME) m_pos = -1;
                end
                if (bus_if.store_in && !m_accept) m_ovf = 1'b1;
                if (m_accept) m_q.push_back(bus_if.data_in[7:0]);
            end
            if (m_pos < 0)              m_tx = 1'b1;
            else if (m_pos / CPB == 0)  m_tx = 1'b0;
            else if (m_pos / CPB <= 8)  m_tx = m_byte[m_pos / CPB - 1];
            else                        m_tx = 1'b1;
            m_busy = (m_pos >= 0) || (m_q.size() > 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                checkOutput("uart_tx", uart_tx, m_tx);
                checkOutput("busy", bus_if.busy, m_busy);
                checkOutput("overflow", bus_if.overflow, m_ovf);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (uart_tx === 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                    rx_shift  = 8'h00;
                end
            end else begin
                rx_cnt++;
                for (int i = 0; i < 8; i++) begin
                    if (rx_cnt == CPB * (i + 1) + CPB / 2) rx_shift[i] = uart_tx;
                end
                if (rx_cnt == 9 * CPB + CPB / 2) begin
                    rx_bytes.push_back(rx_shift);
                    rx_active = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] exp_q[$];

        rstn            = 1'b0;
        bus_if.data_in  = 32'h0;
        bus_if.store_in = 1'b0;

        $display("[TB] reset with store held, then idle line");
        for (int i = 0; i < 3; i++) applyStimulus(32'hFFFF_FF77, 1'b1, 1'b0);
        applyStimulus(32'h0, 1'b0, 1'b1);
        idleCycles(100);
        checkOutput("idle tx", uart_tx, 1'b1);
        checkOutput("idle busy", bus_if.busy, 1'b0);
        exp_q = {};
        checkBytes("idle rx", rx_bytes, exp_q);
        checkBytes("idle model", m_sent, exp_q);

        $display("[TB] single store 0xFFFFFF55");
        applyStimulus(32'hFFFF_FF55, 1'b1, 1'b1);
        for (int k = 0; k <= 41; k++) begin
            applyStimulus(32'h0, 1'b0, 1'b1);
            case (k)
                0: begin
                    checkOutput("t0 tx", uart_tx, 1'b1);
                    checkOutput("t0 busy", bus_if.busy, 1'b1);
                end
                1:  checkOutput("start t1", uart_tx, 1'b0);
                4:  checkOutput("start t4", uart_tx, 1'b0);
                5:  checkOutput("bit0", uart_tx, 1'b1);
                9:  checkOutput("bit1", uart_tx, 1'b0);
                13: checkOutput("bit2", uart_tx, 1'b1);
                33: checkOutput("bit7", uart_tx, 1'b0);
                37: checkOutput("stop", uart_tx, 1'b1);
                40: checkOutput("busy last frame cycle", bus_if.busy, 1'b1);
                41: checkOutput("busy after frame", bus_if.busy, 1'b0);
                default: ;
            endcase
        end
        exp_q = '{8'h55};
        checkBytes("single rx", rx_bytes, exp_q);

        $display("[TB] six back-to-back stores");
        doReset();
        for (int i = 1; i <= 6; i++) applyStimulus(32'h0 | i, 1'b1, 1'b1);
        idleCycles(260);
`ifdef NANOV_UART_FIFO_EN
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
`else
        exp_q = '{8'h01, 8'h02};
`endif
        checkBytes("six rx", rx_bytes, exp_q);
        checkBytes("six model", m_sent, exp_q);
        checkOutput("six overflow", bus_if.overflow, 1'b1);

        $display("[TB] stores A0 A1 A2");
        doReset();
        applyStimulus(32'h1234_56A0, 1'b1, 1'b1);
        applyStimulus(32'h1234_56A1, 1'b1, 1'b1);
        applyStimulus(32'h1234_56A2, 1'b1, 1'b1);
        idleCycles(150);
`ifdef NANOV_UART_FIFO_EN
        exp_q = '{8'hA0, 8'hA1, 8'hA2};
        checkOutput("A overflow", bus_if.overflow, 1'b0);
`else
        exp_q = '{8'hA0, 8'hA1};
        checkOutput("A overflow", bus_if.overflow, 1'b1);
`endif
        checkBytes("A rx", rx_bytes, exp_q);

        $display("[TB] store into full queue on the pop edge");
        doReset();
        exp_q = '{8'hC0};
        applyStimulus(32'h0000_00C0, 1'b1, 1'b1);
        applyStimulus(32'h0, 1'b0, 1'b1);
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(32'h0000_00C0 | i, 1'b1, 1'b1);
            exp_q.push_back(8'hC0 | 8'(i));
        end
        idleCycles(40 - DEPTH);
        applyStimulus(32'h0000_00CF, 1'b1, 1'b1);
        exp_q.push_back(8'hCF);
        idleCycles(2);
        checkOutput("pop-edge overflow", bus_if.overflow, 1'b0);
        idleCycles(FRAME * (DEPTH + 1) + 20);
        checkBytes("pop-edge rx", rx_bytes, exp_q);
        checkOutput("pop-edge overflow end", bus_if.overflow, 1'b0);

        $display("[TB] reset in data bit 3");
        doReset();
        applyStimulus(32'h0000_00D0, 1'b1, 1'b1);
        applyStimulus(32'h0000_00D1, 1'b1, 1'b1);
        idleCycles(16);
        applyStimulus(32'h0, 1'b0, 1'b0);
        applyStimulus(32'h0, 1'b0, 1'b1);
        checkOutput("abort tx", uart_tx, 1'b1);
        checkOutput("abort busy", bus_if.busy, 1'b0);
        idleCycles(100);
        checkOutput("abort tx later", uart_tx, 1'b1);
        checkOutput("abort busy later", bus_if.busy, 1'b0);
        exp_q = {};
        checkBytes("abort rx", rx_bytes, exp_q);
        exp_q = '{8'hD0};
        checkBytes("abort model", m_sent, exp_q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
